// File: rtl/fifo_pkg.sv
// Shared defaults and a clog2 helper for the parametrised synchronous FIFO.
package fifo_pkg;

    localparam int FIFO_DEFAULT_WIDTH = 8;
    localparam int FIFO_DEFAULT_DEPTH = 32;

    // Elaboration-time ceil(log2(value)) for tools without $clog2.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Two-port FIFO storage: synchronous write, read port combinational when
// FIFO_FWFT_EN is defined and registered (reset to zero) otherwise.
module fifo_ram_2p
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_DEFAULT_WIDTH,
    parameter int AW    = clog2(FIFO_DEFAULT_DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rest,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [2**AW];

    // Storage is deliberately left unreset so it can map onto RAM macros.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef FIFO_FWFT_EN
    logic unused_rd_ctrl;

    assign unused_rd_ctrl = i_rest ^ rd_en;
    assign rd_data        = mem[rd_addr];
`else
    always_ff @(posedge i_clk or negedge i_rest) begin
        if (!i_rest) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
`endif

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with count, programmable almost flags and
// error pulses; define FIFO_FWFT_EN for first-word-fall-through reads.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int  WIDTH     = FIFO_DEFAULT_WIDTH,
    parameter int  DEPTH     = FIFO_DEFAULT_DEPTH,
    parameter int  AFULL_TH  = DEPTH - 4,
    parameter int  AEMPTY_TH = 4,
    localparam int AW        = clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rest,
    input  logic             i_wen,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ren,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_afull,
    output logic             o_aempty,
    output logic [AW:0]      o_count,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam logic [AW:0] ONE_C    = (AW + 1)'(1);
    localparam logic [AW:0] DEPTH_C  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AFULL_C  = (AW + 1)'(AFULL_TH);
    localparam logic [AW:0] AEMPTY_C = (AW + 1)'(AEMPTY_TH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             wr_ok;
    logic             rd_ok;
    logic [WIDTH-1:0] ram_rd_data;

    // Accepts look only at registered flags, so a full FIFO never takes a
    // write even when a read frees a slot in the same cycle.
    assign wr_ok = i_wen & ~o_full;
    assign rd_ok = i_ren & ~o_empty;

    always_comb begin
        count_d = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + ONE_C;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - ONE_C;
        end
    end

    // Flags are registered from the next count so they line up with o_count.
    always_ff @(posedge i_clk or negedge i_rest) begin
        if (!i_rest) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            o_full      <= 1'b0;
            o_empty     <= 1'b1;
            o_afull     <= 1'b0;
            o_aempty    <= 1'b1;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + ONE_C;
            end
            if (rd_ok) begin
                rd_ptr_q <= rd_ptr_q + ONE_C;
            end
            count_q     <= count_d;
            o_full      <= (count_d == DEPTH_C);
            o_empty     <= (count_d == '0);
            o_afull     <= (count_d >= AFULL_C);
            o_aempty    <= (count_d <= AEMPTY_C);
            o_overflow  <= i_wen & o_full;
            o_underflow <= i_ren & o_empty;
        end
    end

    assign o_count = count_q;

    fifo_ram_2p #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rest  (i_rest),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (i_data),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (ram_rd_data)
    );

`ifdef FIFO_FWFT_EN
    assign o_data = o_empty ? '0 : ram_rd_data;
`else
    assign o_data = ram_rd_data;
`endif

endmodule
